// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash reader: peripheral register map,
// bit positions, flash command codes and the sequencer state encoding.
package spi_pkg;

  localparam logic [31:0] REG_DATA_OFS = 32'h0;
  localparam logic [31:0] REG_CTRL_OFS = 32'h4;
  localparam logic [31:0] REG_STAT_OFS = 32'h8;

  localparam int unsigned STAT_BUSY_BIT  = 0;
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_MODE_LSB  = 1;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_FETCH,
    ST_PUSH
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  // Header byte by position: command, address MSB..LSB, then 0x00 (dummy/payload)
  function automatic logic [7:0] hdr_byte(input logic [7:0] cmd, input logic [2:0] idx,
                                          input logic [23:0] addr);
    case (idx)
      3'd0:    return cmd;
      3'd1:    return addr[23:16];
      3'd2:    return addr[15:8];
      3'd3:    return addr[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Request, byte-stream and SPI register bus signals of the flash reader.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_len, out_ready, bus_rdata,
    output req_ready, out_valid, out_data, out_last, bus_we, bus_addr, bus_wdata, err
  );

  modport master (
    output req_valid, req_addr, req_len, out_ready, bus_rdata,
    input  req_ready, out_valid, out_data, out_last, bus_we, bus_addr, bus_wdata, err
  );
endinterface

// File: rtl/spi_flash_reader_timer.sv
// Wait-cycle counter: cleared on load, counts while enabled, flags expiry
// once TIMEOUT cycles have been spent in the waiting state.
module spi_flash_reader_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst)                   cnt_q <= '0;
    else if (clear)             cnt_q <= '0;
    else if (en && !expired_c)  cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: rtl/spi_flash_reader.sv
// Reads a byte range from SPI flash by sequencing a memory-mapped SPI
// peripheral. Define SPI_FLASH_FAST_READ_EN for 0x0B + one dummy byte.
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter logic [31:0] REG_BASE = 32'hffff0010,
  parameter logic [1:0]  SPI_MODE = 2'b00,
  parameter int unsigned TIMEOUT  = 1024
) (
  input logic              clk,
  input logic              rst,
  spi_flash_reader_if.slave io
);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]  CMD     = CMD_FAST_READ;
  localparam int unsigned HDR_LEN = 5;
`else
  localparam logic [7:0]  CMD     = CMD_READ;
  localparam int unsigned HDR_LEN = 4;
`endif
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 9;
  localparam logic [31:0] ADDR_DATA = REG_BASE + REG_DATA_OFS;
  localparam logic [31:0] ADDR_CTRL = REG_BASE + REG_CTRL_OFS;
  localparam logic [31:0] ADDR_STAT = REG_BASE + REG_STAT_OFS;

  state_t           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [IDX_W-1:0] hdr_idx_q, hdr_idx_d;
  bus_req_t         bus_q, bus_d;
  logic             req_ready_q, req_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;
  logic             busy_c, expired_c, timer_clear_c, timer_en_c;
  logic             unused_rdata_c;

  assign busy_c         = io.bus_rdata[STAT_BUSY_BIT];
  assign unused_rdata_c = ^io.bus_rdata[31:8];
  assign timer_clear_c  = (state_d != state_q);
  assign timer_en_c     = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_IDLE);

  spi_flash_reader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear_c),
    .en        (timer_en_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      pay_cnt_q   <= '0;
      hdr_idx_q   <= '0;
      bus_q       <= '0;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      bus_q       <= bus_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Next state; registered outputs are decoded from the next state so the bus
  // address lines up with the state that samples bus_rdata.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    pay_cnt_d  = pay_cnt_q;
    hdr_idx_d  = hdr_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    err_d      = 1'b0;
    bus_d      = '0;

    case (state_q)
      ST_IDLE: if (io.req_valid) begin
        addr_d     = io.req_addr;
        len_d      = (io.req_len == 8'd0) ? CNT_W'(256) : CNT_W'(io.req_len);
        pay_cnt_d  = '0;
        hdr_idx_d  = '0;
        out_last_d = 1'b0;
        state_d    = ST_LOAD;
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (busy_c)         state_d = ST_WAIT_IDLE;
        else if (expired_c) begin state_d = ST_IDLE; err_d = 1'b1; end
      end
      ST_WAIT_IDLE: begin
        if (!busy_c)        state_d = ST_FETCH;
        else if (expired_c) begin state_d = ST_IDLE; err_d = 1'b1; end
      end
      ST_FETCH: begin
        if (hdr_idx_q < IDX_W'(HDR_LEN)) begin
          hdr_idx_d = hdr_idx_q + IDX_W'(1);
          state_d   = ST_LOAD;
        end else begin
          out_data_d = io.bus_rdata[7:0];
          pay_cnt_d  = pay_cnt_q + CNT_W'(1);
          out_last_d = ((pay_cnt_q + CNT_W'(1)) == len_q);
          state_d    = ST_PUSH;
        end
      end
      ST_PUSH: if (io.out_ready) begin
        out_last_d = 1'b0;
        state_d    = out_last_q ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_LOAD: begin
        bus_d.we    = 1'b1;
        bus_d.addr  = ADDR_DATA;
        bus_d.wdata = {24'b0, hdr_byte(CMD, hdr_idx_d, addr_d)};
      end
      ST_START: begin
        bus_d.we                           = 1'b1;
        bus_d.addr                         = ADDR_CTRL;
        bus_d.wdata[CTRL_START_BIT]        = 1'b1;
        bus_d.wdata[CTRL_MODE_LSB +: 2]    = SPI_MODE;
      end
      ST_WAIT_BUSY, ST_WAIT_IDLE: bus_d.addr = ADDR_STAT;
      ST_FETCH:                   bus_d.addr = ADDR_DATA;
      default:                    bus_d.addr = '0;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_PUSH);
  end

  assign io.req_ready = req_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_last  = out_last_q;
  assign io.bus_we    = bus_q.we;
  assign io.bus_addr  = bus_q.addr;
  assign io.bus_wdata = bus_q.wdata;
  assign io.err       = err_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: SPI register model with fixed busy time and a
// loopback flash that decodes the command/address bytes it is sent.
module tb_spi_flash_reader;
  import spi_pkg::*;

  localparam logic [31:0] DATA_A = 32'hffff0010;
  localparam logic [31:0] CTRL_A = 32'hffff0014;
  localparam logic [31:0] STAT_A = 32'hffff0018;
  localparam int BUSY_CYC = 3;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         HDR  = 5;
  localparam logic [7:0] TCMD = 8'h0B;
`else
  localparam int         HDR  = 4;
  localparam logic [7:0] TCMD = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_reader_if io ();

  spi_flash_reader #(.REG_BASE(32'hffff0010), .SPI_MODE(2'b00), .TIMEOUT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- peripheral + flash model ----------------
  logic [7:0] tx_log[$];
  logic [7:0] rx_q;
  int         busy_cnt;
  bit         never_busy = 1'b0;
  int         wr_count = 0;
  int         ctrl_bad = 0;
  int         err_pulses = 0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h012345: return 8'hAA;
      24'h012346: return 8'hBB;
      24'h012347: return 8'hCC;
      24'h012348: return 8'hDD;
      default:    return 8'(a[7:0] + a[15:8]);
    endcase
  endfunction

  function automatic logic [7:0] flash_rx();
    int idx;
    idx = tx_log.size() - 1;
    if (idx < HDR) return 8'hFF;
    return flash_byte(24'({tx_log[1], tx_log[2], tx_log[3]} + 24'(idx - HDR)));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      tx_log.delete();
      busy_cnt <= 0;
      rx_q     <= 8'h00;
    end else begin
      if (io.req_valid && io.req_ready) tx_log.delete();
      if (io.err) err_pulses++;
      if (io.bus_we) begin
        wr_count++;
        if (io.bus_addr == DATA_A) tx_log.push_back(io.bus_wdata[7:0]);
        else if (io.bus_addr == CTRL_A) begin
          if (io.bus_wdata != 32'h0000_0001) ctrl_bad++;
          busy_cnt <= never_busy ? 0 : BUSY_CYC;
          rx_q     <= flash_rx();
        end
      end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
  end

  always_comb begin
    case (io.bus_addr)
      STAT_A:  io.bus_rdata = {31'b0, busy_cnt != 0};
      DATA_A:  io.bus_rdata = {24'hA5A5A5, rx_q};
      default: io.bus_rdata = 32'h0;
    endcase
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(io.req_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(io.out_valid), 64'd0);
    check({tag, "_out_last"},  64'(io.out_last),  64'd0);
    check({tag, "_out_data"},  64'(io.out_data),  64'd0);
    check({tag, "_err"},       64'(io.err),       64'd0);
    check({tag, "_bus_we"},    64'(io.bus_we),    64'd0);
    check({tag, "_bus_addr"},  64'(io.bus_addr),  64'd0);
    check({tag, "_bus_wdata"}, 64'(io.bus_wdata), 64'd0);
  endtask

  task automatic issue_req(input logic [23:0] addr, input logic [7:0] len);
    int n = 0;
    while (!io.req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_before_req", 64'(io.req_ready), 64'd1);
    io.req_addr  = addr;
    io.req_len   = len;
    io.req_valid = 1'b1;
    @(negedge clk);
    io.req_valid = 1'b0;
    check("first_load", {31'b0, io.bus_we, io.bus_addr},
          {31'b0, 1'b1, DATA_A});
  endtask

  task automatic run_txn(input logic [23:0] addr, input logic [7:0] len, input int stall_at,
                         input int exp_cnt, input logic [7:0] exp_first,
                         input logic [7:0] exp_last);
    int         idx = 0;
    int         cycles = 0;
    bit         done = 1'b0;
    int         err0 = err_pulses;
    logic [7:0] first_b = 8'h00;
    logic [7:0] last_b  = 8'h00;
    int         nz = 0;
    io.out_ready = 1'b1;
    issue_req(addr, len);
    check("cmd_byte", 64'(io.bus_wdata), 64'(TCMD));
    while (!done && cycles < 20000) begin
      if (io.out_valid) begin
        if (idx == stall_at) begin
          logic [7:0] held = io.out_data;
          int         wc   = wr_count;
          bit         stable = 1'b1;
          io.out_ready = 1'b0;
          for (int k = 0; k < 20; k++) begin
            io.req_valid = (k == 0);
            @(negedge clk);
            if (k == 0) check("busy_req_ready", 64'(io.req_ready), 64'd0);
            if (!io.out_valid || io.out_data !== held) stable = 1'b0;
          end
          io.req_valid = 1'b0;
          check("stall_stable", 64'(stable), 64'd1);
          check("stall_no_writes", 64'(wr_count), 64'(wc));
          io.out_ready = 1'b1;
        end
        check($sformatf("byte%0d", idx), {55'b0, io.out_last, io.out_data},
              {55'b0, (idx == exp_cnt - 1), flash_byte(24'(addr + 24'(idx)))});
        if (idx == 0) first_b = io.out_data;
        last_b = io.out_data;
        done   = io.out_last;
        idx++;
      end
      @(negedge clk);
      cycles++;
    end
    if (!done) check("txn_budget", 64'd0, 64'd1);
    @(negedge clk);
    check("count", 64'(idx), 64'(exp_cnt));
    check("first", 64'(first_b), 64'(exp_first));
    check("last", 64'(last_b), 64'(exp_last));
    check("idle_after", 64'(io.req_ready), 64'd1);
    check("no_err", 64'(err_pulses), 64'(err0));
    check("tx_count", 64'(tx_log.size()), 64'(HDR + exp_cnt));
    if (tx_log.size() >= 4)
      check("header", 64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3]}), 64'({TCMD, addr}));
    else
      check("header_short", 64'(tx_log.size()), 64'd4);
    for (int i = 4; i < tx_log.size(); i++) if (tx_log[i] != 8'h00) nz++;
    check("tx_zeros", 64'(nz), 64'd0);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    int          stall_at;
    int          exp_cnt;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  initial begin
    vec_t vecs[5];
    io.req_valid = 1'b0;
    io.req_addr  = '0;
    io.req_len   = '0;
    io.out_ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{24'h012345, 8'd4, -1, 4,   8'hAA, 8'hDD};
    vecs[1] = '{24'h000100, 8'd0, -1, 256, 8'h01, 8'h00};
    vecs[2] = '{24'h001000, 8'd3,  1, 3,   8'h10, 8'h12};
    vecs[3] = '{24'h00FFFF, 8'd2, -1, 2,   8'hFE, 8'h00};
    vecs[4] = '{24'h0000FE, 8'd1, -1, 1,   8'hFE, 8'hFE};
    foreach (vecs[i])
      run_txn(vecs[i].addr, vecs[i].len, vecs[i].stall_at, vecs[i].exp_cnt,
              vecs[i].exp_first, vecs[i].exp_last);
    check("ctrl_writes", 64'(ctrl_bad), 64'd0);

    // Peripheral never reports busy: expect timeout abort
    begin
      int stat = 0, ov = 0, n = 0, err0, wc;
      never_busy = 1'b1;
      err0 = err_pulses;
      issue_req(24'h001000, 8'd2);
      while (!io.err && n < 1500) begin
        if (io.bus_addr == STAT_A && !io.bus_we) stat++;
        if (io.out_valid) ov++;
        @(negedge clk);
        n++;
      end
      check("err_seen", 64'(io.err), 64'd1);
      check("stat_cycles", 64'(stat), 64'd1024);
      check("to_ready", 64'(io.req_ready), 64'd1);
      wc = wr_count;
      repeat (10) begin
        if (io.out_valid) ov++;
        @(negedge clk);
      end
      check("to_err_once", 64'(err_pulses - err0), 64'd1);
      check("to_no_out", 64'(ov), 64'd0);
      check("to_no_writes", 64'(wr_count), 64'(wc));
      never_busy = 1'b0;
    end

    // Reset during the third payload byte
    begin
      int n = 0, err0, ov = 0;
      io.out_ready = 1'b1;
      issue_req(24'h002000, 8'd5);
      while (tx_log.size() < HDR + 3 && n < 3000) begin @(negedge clk); n++; end
      check("reached_byte3", 64'(tx_log.size()), 64'(HDR + 3));
      repeat (2) @(negedge clk);
      err0 = err_pulses;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (io.out_valid || io.out_last) ov++;
      end
      check("midrst_no_err", 64'(err_pulses), 64'(err0));
      check("midrst_quiet", 64'(ov), 64'd0);
      run_txn(24'h000200, 8'd2, -1, 2, 8'h02, 8'h03);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter REG_BASE, default 32'hffff0010, SPI peripheral register base (DATA = base+0, CTRL = base+4, STAT = base+8).
REQ-002 SHALL have parameter SPI_MODE, default 2'b00, {CPHA,CPOL} written into CTRL[2:1].
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles spent waiting on STAT per byte.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  read request strobe.
REQ-007 req_ready  output  1  high only in IDLE.
REQ-008 req_addr  input  24  flash byte address.
REQ-009 req_len  input  8  bytes to read; 0 means 256.
REQ-010 out_valid / out_ready / out_data[7:0] / out_last  out/in/out/out  byte stream; out_last on final byte.
REQ-011 bus_we  output  1  register write strobe to SPI peripheral.
REQ-012 bus_addr  output  32  register address.
REQ-013 bus_wdata  output  32  write data.
REQ-014 bus_rdata  input  32  read data, valid in the same cycle bus_addr is presented with bus_we=0.
REQ-015 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-016 Request accepted when req_valid && req_ready; req_addr and req_len latched that cycle.
REQ-017 Transfer byte sequence: 0x03, addr[23:16], addr[15:8], addr[7:0], then len bytes of TX 0x00; RX of header bytes discarded.
REQ-018 Per byte, FSM SHALL step LOAD -> START -> WAIT_BUSY -> WAIT_IDLE -> FETCH [-> PUSH] -> next byte or IDLE.
REQ-019 LOAD: one cycle, bus_we=1, bus_addr=DATA, bus_wdata={24'b0,tx_byte}.
REQ-020 START: one cycle, bus_we=1, bus_addr=CTRL, bus_wdata={29'b0,SPI_MODE,1'b1}.
REQ-021 WAIT_BUSY: bus_addr=STAT, bus_we=0; advance when bus_rdata[0]=1.
REQ-022 WAIT_IDLE: bus_addr=STAT, bus_we=0; advance when bus_rdata[0]=0.
REQ-023 FETCH: one cycle, bus_addr=DATA, bus_we=0; capture bus_rdata[7:0]; header bytes go to LOAD of next byte, payload bytes go to PUSH.
REQ-024 PUSH: out_valid=1 holding captured byte until out_ready; out_data stable while out_valid && !out_ready.
REQ-025 out_last=1 with the byte whose payload count reaches len; after that handshake return to IDLE.
REQ-026 Payload counter 9 bits; len 0 loads 256; no wrap of the 24-bit flash address is performed by this block.
REQ-027 Wait counter SHALL clear on entry to WAIT_BUSY and WAIT_IDLE; reaching TIMEOUT in either state SHALL pulse err, drive no further bus writes, return to IDLE; out_valid stays 0.
REQ-028 bus_we SHALL be 0 in every state other than LOAD and START.
REQ-029 req_valid while busy SHALL be ignored (req_ready=0), not queued.
REQ-030 Minimum latency req accept -> first LOAD SHALL be one cycle.

Reset
REQ-031 rst=0 SHALL force IDLE, counters 0, req_ready=1 on the following cycle, out_valid=0, out_last=0, out_data=0, err=0, bus_we=0, bus_addr=0, bus_wdata=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no err pulse and no partial out_last.

Configuration
REQ-033 Macro SPI_FLASH_FAST_READ_EN defined: command byte 0x0B and one dummy byte (TX 0x00, RX discarded) inserted after addr[7:0].
REQ-034 Macro undefined: command 0x03, no dummy byte; header is exactly 4 bytes.

Structure
REQ-035 Shared package spi_pkg SHALL hold register offsets (DATA/CTRL/STAT), STAT busy bit index, CTRL bit indices, flash command codes 0x03/0x0B, and the FSM state enum.
REQ-036 One sub-module spi_flash_reader_timer (loadable wait counter with expiry flag) is natural; everything else flat.

Verification (bench uses a behavioural SPI register model with a fixed 2-byte-per-cycle-independent busy time and loopback flash model)
REQ-037 req_addr=24'h012345, len=4, flash holds AA BB CC DD -> bus writes DATA 0x03,0x01,0x23,0x45 then 4x 0x00; out bytes AA,BB,CC,DD, out_last on DD only.
REQ-038 len=0 -> exactly 256 out bytes, out_last on the 256th, counter no wrap.
REQ-039 out_ready held 0 for 20 cycles on byte 2 -> out_data/out_valid stable, no further bus writes until handshake.
REQ-040 model never asserts busy -> err pulses once after TIMEOUT=1024 cycles in WAIT_BUSY, return to IDLE, no out_valid.
REQ-041 rst=0 during third payload byte -> next cycle all outputs at reset values, new request afterwards completes normally.
REQ-042 with SPI_FLASH_FAST_READ_EN, addr 24'h000010, len=1 -> DATA writes 0x0B,0x00,0x00,0x10,0x00,0x00; one out byte.
